// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end. Owns the PC, issues word-aligned
// fetches over a req/gnt interface, tracks in-flight PCs, buffers returned
// words in a 2-entry FIFO for decode and squashes stale fetches on redirect.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect -> ERR).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        fetch_err
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned CRED_W = CNT_W + 1;

    localparam logic [0:0] ST_RUN = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [0:0] ST_ERR = 1'b1;
`endif

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] word;
    } fetch_entry_t;

    logic [0:0]       state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic             valid_q;
    fetch_entry_t     fifo_q [2];
    fetch_entry_t     fifo_d [2];
    logic [XLEN-1:0]  ifl_q [2];
    logic [XLEN-1:0]  ifl_d [2];

    logic              deq_c;
    logic              grant_c;
    logic [CRED_W-1:0] credits_c;
    logic [XLEN-1:0]   target_c;

    // Request gating: credits count everything that may still land in the FIFO
    assign deq_c     = valid_q & inst_ready;
    assign credits_c = CRED_W'(outst_q) + CRED_W'(fcnt_q) - CRED_W'(deq_c);
    assign imem_req  = resetn & (state_q == ST_RUN) & (credits_c < CRED_W'(2)) & ~redirect_valid;
    assign grant_c   = imem_req & imem_gnt;
    assign target_c  = {redirect_pc[XLEN-1:2], 2'b00};

    assign imem_addr  = pc_q;
    assign inst_valid = valid_q;
    assign inst_data  = fifo_q[0].word;
    assign inst_pc    = fifo_q[0].pc;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_c;
    assign misalign_c = |redirect_pc[1:0];
    assign fetch_err  = (state_q == ST_ERR);
`else
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^redirect_pc[1:0];
    assign fetch_err     = 1'b0;
`endif

    // Next-state: in-flight queue, drop accounting, FIFO, PC and FSM
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        outst_d = outst_q;
        drop_d  = drop_q;
        fcnt_d  = fcnt_q;
        fifo_d  = fifo_q;
        ifl_d   = ifl_q;

        if (imem_rvalid) begin
            ifl_d[0] = ifl_q[1];
            outst_d  = outst_q - CNT_W'(1);
        end
        if (grant_c) begin
            if (outst_d == '0) begin
                ifl_d[0] = pc_q;
            end else begin
                ifl_d[1] = pc_q;
            end
            outst_d = outst_d + CNT_W'(1);
            pc_d    = pc_q + 32'd4;
        end

        if (deq_c) begin
            fifo_d[0] = fifo_q[1];
            fcnt_d    = fcnt_q - CNT_W'(1);
        end
        if (imem_rvalid) begin
            if (drop_q != '0) begin
                drop_d = drop_q - CNT_W'(1);
            end else if (!redirect_valid) begin
                if (fcnt_d == '0) begin
                    fifo_d[0].pc   = ifl_q[0];
                    fifo_d[0].word = imem_rdata;
                end else begin
                    fifo_d[1].pc   = ifl_q[0];
                    fifo_d[1].word = imem_rdata;
                end
                fcnt_d = fcnt_d + CNT_W'(1);
            end
        end

        // Redirect squashes buffered words and every fetch still in flight
        if (redirect_valid) begin
            pc_d    = target_c;
            fcnt_d  = '0;
            drop_d  = outst_d;
            state_d = ST_RUN;
`ifdef FETCH_ALIGN_CHECK_EN
            if (misalign_c) begin
                state_d = ST_ERR;
            end
`endif
        end
    end

    // State registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
            fcnt_q  <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
                ifl_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
            fcnt_q  <= fcnt_d;
            valid_q <= (fcnt_d != '0);
            fifo_q  <= fifo_d;
            ifl_q   <= ifl_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end for the MIPS core. It owns the program counter, issues word-aligned fetch addresses to instruction memory over a request/grant interface and advances the PC by 4 on every grant. It buffers returned instruction words with their PCs in a 2-entry FIFO for decode, and handles branch/jump redirects by flushing stale fetches. It sits between instruction memory and the decode stage.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  new fetch target.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address, bits [1:0] always 0.
- imem_gnt  in  1  address accepted this cycle (only meaningful with imem_req).
- imem_rvalid  in  1  returned word valid; responses are in order, at least 1 cycle after grant.
- imem_rdata  in  32  returned instruction word.
- inst_valid  out  1  buffered instruction available.
- inst_ready  in  1  decode accepts.
- inst_data  out  32  instruction at buffer head.
- inst_pc  out  32  PC of inst_data.
- fetch_err  out  1  misaligned-redirect error (see Configuration).

## Operation
- State: pc, outstanding count (0..2), drop count (0..2), 2-entry FIFO {pc, word}, 2-entry in-flight PC queue, FSM {RUN, ERR}.
- Credits = outstanding + FIFO occupancy − (inst_valid & inst_ready). imem_req = (state==RUN) & (credits < 2) & !redirect_valid.
- Grant (imem_req & imem_gnt): push pc to in-flight queue, outstanding+1, pc <= pc + 32'd4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
- Response (imem_rvalid): pop in-flight queue, outstanding−1; if drop count > 0, discard word and decrement drop count, else push {pc, rdata} into FIFO.
- Redirect: pc <= redirect_pc; FIFO flushed; drop count <= outstanding after this cycle's events; no request issued this cycle. A response arriving in the redirect cycle is discarded. An inst handshake in the redirect cycle completes (the instruction counts as delivered).
- Redirect while drops still pending: drop counts accumulate (saturate at 2, cannot exceed outstanding).
- imem_addr may change between cycles while ungranted (only on redirect).
- FIFO never overflows by construction; credit check guarantees room.

## Timing
- Reset values: pc=RESET_PC, imem_req=0 during reset, imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, fetch_err=0, counts 0, state RUN.
- First cycle after resetn rises: imem_req=1, imem_addr=RESET_PC.
- Latency: rvalid at cycle t → inst_valid=1 at t+1 (FIFO registered, no bypass).
- With 1-cycle memory and inst_ready held 1: one instruction per cycle sustained.
- Redirect at cycle t: inst_valid=0 at t+1; first request to redirect_pc at t+1.
- Reset asserted mid-operation: all state cleared immediately; in-flight responses after reset release are not tracked (memory must also be reset).

## Configuration
- FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0] != 0 enters ERR: fetch_err=1 next cycle, imem_req=0, FIFO flushed, outstanding responses dropped; an aligned redirect returns to RUN and clears fetch_err.
- Undefined: redirect_pc[1:0] is forced to 00, ERR state absent, fetch_err tied 0.

## Test plan
- Reset release, 1-cycle memory, inst_ready=1: addrs 0x0,0x4,0x8… one per cycle; inst_pc 0x0 at cycle 2 after release, sequence unbroken.
- inst_ready=0 held: exactly 2 grants, then imem_req=0; inst_valid=1, inst_pc=0x0; release ready → fetching resumes next cycle.
- Redirect to 0x100 with 2 outstanding: both responses discarded, next delivered inst_pc=0x100, no stale word reaches decode.
- Redirect in the same cycle as rvalid and inst handshake: handshaked word delivered once, arriving word dropped, next inst_pc = target.
- Redirect to 0xFFFF_FFFC: fetches 0xFFFF_FFFC then 0x0000_0000.
- Redirect to 0x102: with FETCH_ALIGN_CHECK_EN fetch_err=1, no req until redirect to 0x200; without it fetch resumes at 0x100.
